uart_tx_frame_gen: RTL and testbench

- Parameterised UART transmitter with an input byte FIFO.
- Sits directly upstream of the UART checker's receive input (i_rx) in the UART test environment. It is the serial source whose frames the checker decodes.
- Parameter set and semantics match the checker so both sides agree on the frame format.
- Bytes are pushed via a valid/ready handshake, buffered, and serialised back-to-back on o_tx.

---
 rtl/uart_tb_pkg.sv | 37 +++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_frame_gen.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_frame_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tb_pkg.sv
// Shared UART definitions: baud table, parity and bit-order encodings, divisor math.
// Latency: n/a (compile-time constants and a constant function only).
// Backpressure: n/a.
package uart_tb_pkg;

   // Baud rates selectable by index 0..9.
   localparam int BAUD_TABLE [0:10-1] = '{300, 600, 1200, 2400, 4800,
                                          9600, 19200, 38400, 57600, 115200};

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   localparam int FIRST_BIT_LSB = 0;
   localparam int FIRST_BIT_MSB = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // Clock cycles per serial bit; an out-of-range index yields 0 so the
   // caller's divisor check rejects it.
   function automatic int calc_div(input int clock_freq, input int baud_idx);
      if (baud_idx < 0 || baud_idx > 9) begin
         return 0;
      end
      return clock_freq / BAUD_TABLE[baud_idx];
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO, registered pointers with wrap bit, sticky overflow flag.
// Latency: a pushed word is visible at the head the cycle after the push; head data is combinational.
// Backpressure: push_rdy low when full; a push while full is dropped and sets overflow (set beats clear).
module uart_tx_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_vld,
   input  logic [DW-1:0] push_dat,
   output logic          push_rdy,
   input  logic          pop_en,
   output logic [DW-1:0] pop_dat,
   output logic          empty,
   output logic          overflow,
   input  logic          clr_overflow
);
   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          push_acc;
   logic          pop_acc;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_rdy = ~full;
   assign push_acc = push_vld & ~full;
   assign pop_acc  = pop_en & ~empty;
   assign pop_dat  = mem[rd_ptr[AW-1:0]];

   // Pointer update; wrap bit distinguishes full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_acc)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: contents are only read behind a valid pointer.
   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

   // Sticky overflow: a refused push sets it, and setting wins over a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                overflow <= 1'b0;
      else if (push_vld && full) overflow <= 1'b1;
      else if (clr_overflow)     overflow <= 1'b0;
   end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: buffers pushed words and serialises them back-to-back on o_tx.
// Latency: word accepted at edge N drives the start bit from edge N+2 when idle.
// Backpressure: o_ready low while the FIFO is full; pushes then are dropped and flagged in o_overflow.
module uart_tx_frame_gen
   import uart_tb_pkg::*;
#(
   parameter int G_STOP_BIT_NUMBER = 1,
   parameter int G_POLARITY        = 1,
   parameter int G_PARITY          = 0,
   parameter int G_BAUDRATE        = 9,
   parameter int G_DATA_WIDTH      = 8,
   parameter int G_FIRST_BIT       = 0,
   parameter int G_CLOCK_FREQ      = 20000000,
   parameter int G_FIFO_ADDR_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [G_DATA_WIDTH-1:0] i_data,
   input  logic                    i_data_valid,
   output logic                    o_ready,
   output logic                    o_tx,
   output logic                    o_busy,
   output logic                    o_fifo_empty,
   output logic                    o_overflow,
   input  logic                    i_clr_overflow
);
   localparam int   DW         = G_DATA_WIDTH;
   localparam int   DIV        = calc_div(G_CLOCK_FREQ, G_BAUDRATE);
   localparam int   STOP_LEN   = G_STOP_BIT_NUMBER * DIV;
   localparam int   CW         = $clog2(STOP_LEN);
   localparam int   BW         = $clog2(DW);
   localparam bit   MSB_FIRST  = (G_FIRST_BIT == FIRST_BIT_MSB);
   localparam bit   HAS_PARITY = (G_PARITY != int'(PAR_NONE));
   localparam logic PAR_INV    = (G_PARITY == int'(PAR_ODD));

   localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
   localparam logic [CW-1:0] STOP_PRE  = CW'(STOP_LEN - 2);
   localparam logic [BW-1:0] DATA_LAST = BW'(DW - 1);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_frame_gen: clock too slow for the selected baud rate");
   end
   if (G_PARITY < int'(PAR_NONE) || G_PARITY > int'(PAR_ODD)) begin : g_bad_parity
      $error("uart_tx_frame_gen: parity mode must be 0, 1 or 2");
   end
   if (G_STOP_BIT_NUMBER < 1 || G_STOP_BIT_NUMBER > 2) begin : g_bad_stop
      $error("uart_tx_frame_gen: stop bit count must be 1 or 2");
   end
   if (DW < 5 || DW > 9) begin : g_bad_width
      $error("uart_tx_frame_gen: data width must be 5..9");
   end
   if (G_FIRST_BIT != FIRST_BIT_LSB && G_FIRST_BIT != FIRST_BIT_MSB) begin : g_bad_order
      $error("uart_tx_frame_gen: bit order must be 0 or 1");
   end

   tx_state_e     state;
   tx_state_e     state_next;
   logic [CW-1:0] baud_cnt;
   logic [BW-1:0] bit_idx;
   logic [DW-1:0] shift_q;
   logic          par_q;
   logic          bit_end;
   logic          fifo_pop;
   logic          fifo_empty;
   logic          push_rdy;
   logic [DW-1:0] fifo_dat;
   logic          tx_mark;
   logic          busy_q;

   uart_tx_fifo #(
      .DW (DW),
      .AW (G_FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_vld     (i_data_valid),
      .push_dat     (i_data),
      .push_rdy     (push_rdy),
      .pop_en       (fifo_pop),
      .pop_dat      (fifo_dat),
      .empty        (fifo_empty),
      .overflow     (o_overflow),
      .clr_overflow (i_clr_overflow)
   );

   assign bit_end = (baud_cnt == BIT_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next state, FIFO pop and logical line value (1 = mark). When more data is
   // queued, LOAD takes the place of the last stop cycle so frames abut exactly.
   always_comb begin
      state_next = state;
      fifo_pop   = 1'b0;
      tx_mark    = 1'b1;
      unique case (state)
         ST_IDLE: begin
            if (!fifo_empty) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            fifo_pop   = 1'b1;
            state_next = ST_START;
         end
         ST_START: begin
            tx_mark = 1'b0;
            if (bit_end) state_next = ST_DATA;
         end
         ST_DATA: begin
            tx_mark = MSB_FIRST ? shift_q[DW-1] : shift_q[0];
            if (bit_end && bit_idx == DATA_LAST) begin
               state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            tx_mark = par_q;
            if (bit_end) state_next = ST_STOP;
         end
         ST_STOP: begin
            if (!fifo_empty && (baud_cnt == STOP_PRE || baud_cnt == STOP_LAST)) begin
               state_next = ST_LOAD;
            end else if (baud_cnt == STOP_LAST) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Baud counter restarts on every state change and at each data-bit boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt <= '0;
      end else if (state_next != state || (state == ST_DATA && bit_end)) begin
         baud_cnt <= '0;
      end else if (state != ST_IDLE) begin
         baud_cnt <= baud_cnt + CW'(1);
      end
   end

   // Shift register, data bit index and parity captured when the word is popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         bit_idx <= '0;
         par_q   <= 1'b0;
      end else if (state == ST_LOAD) begin
         shift_q <= fifo_dat;
         bit_idx <= '0;
         par_q   <= (^fifo_dat) ^ PAR_INV;
      end else if (state == ST_DATA && bit_end) begin
         shift_q <= MSB_FIRST ? {shift_q[DW-2:0], 1'b0} : {1'b0, shift_q[DW-1:1]};
         bit_idx <= bit_idx + BW'(1);
      end
   end

   // Busy reflects the state and FIFO occupancy after this edge, so it drops
   // on the same edge the stop bit ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= 1'b0;
      else        busy_q <= (state_next != ST_IDLE) | ~fifo_empty | (i_data_valid & push_rdy);
   end

   assign o_tx         = (G_POLARITY != 0) ? tx_mark : ~tx_mark;
   assign o_ready      = push_rdy;
   assign o_fifo_empty = fifo_empty;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: two instances (8N1 LSB-first at 20 MHz/115200, and
// 8O2 MSB-first inverted line with DIV = 8), scoreboard queues fed by stimulus and
// cycle-exact line monitors that decode each frame against a reference waveform.
module tb_uart_tx_frame_gen;

   localparam int DIV_A   = 173;          // 20_000_000 / 115200
   localparam int FRAME_A = 10 * DIV_A;   // start + 8 data + 1 stop
   localparam int DIV_B   = 8;            // 921_600 / 115200
   localparam int FRAME_B = 12 * DIV_B;   // start + 8 data + parity + 2 stop

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   int         cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] dat_a, dat_b;
   logic       vld_a, vld_b, clr_a, clr_b;
   logic       rdy_a, tx_a, busy_a, emp_a, ovf_a;
   logic       rdy_b, tx_b, busy_b, emp_b, ovf_b;

   uart_tx_frame_gen u_dut_a (
      .clk (clk), .rst_n (rst_n), .i_data (dat_a), .i_data_valid (vld_a),
      .o_ready (rdy_a), .o_tx (tx_a), .o_busy (busy_a), .o_fifo_empty (emp_a),
      .o_overflow (ovf_a), .i_clr_overflow (clr_a)
   );

   uart_tx_frame_gen #(
      .G_STOP_BIT_NUMBER (2), .G_POLARITY (0), .G_PARITY (2), .G_BAUDRATE (9),
      .G_DATA_WIDTH (8), .G_FIRST_BIT (1), .G_CLOCK_FREQ (921600), .G_FIFO_ADDR_WIDTH (2)
   ) u_dut_b (
      .clk (clk), .rst_n (rst_n), .i_data (dat_b), .i_data_valid (vld_b),
      .o_ready (rdy_b), .o_tx (tx_b), .o_busy (busy_b), .o_fifo_empty (emp_b),
      .o_overflow (ovf_b), .i_clr_overflow (clr_b)
   );

   int         errors = 0;
   int         checks = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int         start_a[$];
   int         frames [2];
   bit         in_frame [2];
   int         last_push;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Line level for frame bit b (0 = start, 1..8 = data, then parity, then stop).
   function automatic logic exp_level(input logic pol, input logic msb, input int par,
                                      input logic [7:0] d, input int b);
      logic m;
      if (b == 0)                     m = 1'b0;
      else if (b <= 8)                m = msb ? d[8-b] : d[b-1];
      else if (par != 0 && b == 9)    m = (par == 2) ? ~(^d) : (^d);
      else                            m = 1'b1;
      return m ? pol : ~pol;
   endfunction

   // Watches one line: on each start bit pops the expected byte, compares every
   // cycle of the frame and decodes data from mid-bit samples.
   task automatic monitor(input int k);
      int         div, frame, par, j, bad, idx;
      logic       pol, msb, line, aborted;
      logic [7:0] exp_b, dec;
      div   = (k == 0) ? DIV_A : DIV_B;
      frame = (k == 0) ? FRAME_A : FRAME_B;
      par   = (k == 0) ? 0 : 2;
      pol   = (k == 0);
      msb   = (k != 0);
      forever begin
         @(negedge clk);
         line = (k == 0) ? tx_a : tx_b;
         if (rst_n && line !== pol) begin
            in_frame[k] = 1'b1;
            if (k == 0) start_a.push_back(cyc);
            check($sformatf("byte_pending_dut%0d", k),
                  int'(((k == 0) ? q_a.size() : q_b.size()) > 0), 1);
            exp_b = 8'h00;
            if (k == 0 && q_a.size() > 0) exp_b = q_a.pop_front();
            if (k != 0 && q_b.size() > 0) exp_b = q_b.pop_front();
            j = 0; bad = 0; dec = 8'h00; aborted = 1'b0;
            while (j < frame) begin
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               line = (k == 0) ? tx_a : tx_b;
               if (line !== exp_level(pol, msb, par, exp_b, j / div)) bad++;
               if ((j % div) == div / 2 && j / div >= 1 && j / div <= 8) begin
                  idx = j / div - 1;
                  dec[msb ? 7 - idx : idx] = (line == pol);
               end
               j++;
               if (j < frame) @(negedge clk);
            end
            if (!aborted) begin
               check($sformatf("waveform_dut%0d_byte%02h", k, exp_b), bad, 0);
               check($sformatf("decoded_dut%0d", k), int'(dec), int'(exp_b));
               frames[k]++;
            end
            in_frame[k] = 1'b0;
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   // Called at a negedge: presents one word for one cycle and queues it if accepted.
   task automatic push(input int k, input logic [7:0] d, output bit acc);
      if (k == 0) begin dat_a = d; vld_a = 1'b1; acc = rdy_a; end
      else        begin dat_b = d; vld_b = 1'b1; acc = rdy_b; end
      if (acc) begin
         if (k == 0) q_a.push_back(d);
         else        q_b.push_back(d);
      end
      last_push = cyc + 1;
      @(negedge clk);
      vld_a = 1'b0;
      vld_b = 1'b0;
   endtask

   task automatic wait_drain(input int k, input int bound, input string name);
      int i;
      i = 0;
      while (i < bound && !(((k == 0) ? q_a.size() : q_b.size()) == 0 && !in_frame[k]
                            && !((k == 0) ? busy_a : busy_b))) begin
         @(negedge clk);
         i++;
      end
      check(name, int'(i < bound), 1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int bad, n0, st, fall, f0, nacc;
      rst_n = 1'b0;
      vld_a = 1'b0; vld_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      dat_a = 8'h00; dat_b = 8'h00;
      repeat (5) @(negedge clk);

      check("reset_tx_a", int'(tx_a), 1);
      check("reset_ready_a", int'(rdy_a), 1);
      check("reset_busy_a", int'(busy_a), 0);
      check("reset_empty_a", int'(emp_a), 1);
      check("reset_overflow_a", int'(ovf_a), 0);
      check("reset_tx_b_idle_low", int'(tx_b), 0);
      check("reset_flags_b", int'({rdy_b, busy_b, emp_b, ovf_b}), 4'b1010);
      rst_n = 1'b1;

      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || rdy_a !== 1'b1 || busy_a !== 1'b0) bad++;
      end
      check("idle_1000_cycles", bad, 0);

      // Single 0xA5: start-bit latency and busy duration.
      n0 = start_a.size();
      push(0, 8'hA5, acc);
      check("a5_accepted", int'(acc), 1);
      for (int i = 0; i < 20 && start_a.size() == n0; i++) @(negedge clk);
      check("a5_start_seen", int'(start_a.size() > n0), 1);
      st = (start_a.size() > n0) ? start_a[n0] : 0;
      check("a5_start_latency", st - last_push, 2);
      fall = -1;
      for (int i = 0; i < 4000 && fall < 0; i++) begin
         @(negedge clk);
         if (!busy_a) fall = cyc;
      end
      check("a5_busy_fall", fall - st, FRAME_A);
      wait_drain(0, 4000, "a5_drain");

      // Inverted-line, odd-parity, MSB-first instance: directed then random words.
      push(1, 8'h81, acc);
      check("b_81_accepted", int'(acc), 1);
      wait_drain(1, 500, "b_81_drain");
      push(1, 8'hFF, acc);
      check("b_ff_accepted", int'(acc), 1);
      wait_drain(1, 500, "b_ff_drain");
      for (int n = 0; n < 20; n++) begin
         for (int w = 0; w < 500 && !rdy_b; w++) @(negedge clk);
         push(1, 8'($urandom_range(0, 255)), acc);
         repeat ($urandom_range(0, 150)) @(negedge clk);
      end
      wait_drain(1, 4000, "b_random_drain");

      // Burst into the depth-16 FIFO; one word leaves for the shifter, so the 17th fills it.
      n0 = start_a.size();
      nacc = 0;
      for (int i = 0; i <= 16; i++) begin
         push(0, 8'(i), acc);
         nacc += int'(acc);
      end
      check("burst_accepted", nacc, 17);
      check("burst_full_ready_low", int'(rdy_a), 0);
      dat_a = 8'hEE; vld_a = 1'b1;
      @(negedge clk);
      vld_a = 1'b0;
      check("overflow_set", int'(ovf_a), 1);
      vld_a = 1'b1; clr_a = 1'b1;
      @(negedge clk);
      vld_a = 1'b0; clr_a = 1'b0;
      check("overflow_set_wins_over_clear", int'(ovf_a), 1);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("overflow_cleared", int'(ovf_a), 0);
      wait_drain(0, 17 * FRAME_A + 4000, "burst_drain");
      check("burst_frame_count", start_a.size() - n0, 17);
      bad = 0;
      for (int i = 1; i < 17 && n0 + i < start_a.size(); i++) begin
         if (start_a[n0+i] - start_a[n0+i-1] != FRAME_A) bad++;
      end
      check("burst_back_to_back", bad, 0);

      // Random words with random gaps on the default instance.
      for (int n = 0; n < 4; n++) begin
         push(0, 8'($urandom_range(0, 255)), acc);
         repeat ($urandom_range(0, 1500)) @(negedge clk);
      end
      wait_drain(0, 4 * FRAME_A + 4000, "a_random_drain");

      // Reset in the middle of a data bit with three words still queued.
      n0 = start_a.size();
      push(0, 8'h3C, acc);
      push(0, 8'h11, acc);
      push(0, 8'h22, acc);
      push(0, 8'h33, acc);
      for (int i = 0; i < 20 && start_a.size() == n0; i++) @(negedge clk);
      check("reset_test_start_seen", int'(start_a.size() > n0), 1);
      st = (start_a.size() > n0) ? start_a[n0] : cyc;
      for (int i = 0; i < 2000 && cyc < st + 4 * DIV_A + 40; i++) @(negedge clk);
      rst_n = 1'b0;
      q_a.delete();
      f0 = frames[0];
      #1;
      check("midframe_reset_tx_idle", int'(tx_a), 1);
      check("midframe_reset_fifo_empty", int'(emp_a), 1);
      check("midframe_reset_ready", int'(rdy_a), 1);
      check("midframe_reset_busy", int'(busy_a), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3000) @(negedge clk);
      check("no_frame_after_reset", frames[0] - f0, 0);
      check("no_start_after_reset", start_a.size() - n0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
